// File: rtl/rpc_config_path_pkg.sv
// Shared types for the RPC DRAM command path: command source tags and
// the output slot state encoding.
package rpc_config_path_pkg;

  typedef enum logic [1:0] {
    SRC_DIRECT = 2'd0,
    SRC_ACC    = 2'd1,
    SRC_REF    = 2'd2,
    SRC_ZQC    = 2'd3
  } rpc_cmd_src_e;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  localparam int unsigned RPC_CMD_WIDTH = 19;

endpackage

// File: rtl/rpc_cmd_scheduler_if.sv
// Handshake bundle between the four command requesters, the scheduler and CMD_FSM.
// The scheduler sits on the slave side; requesters/CMD_FSM drive the master side.
interface rpc_cmd_scheduler_if #(
  parameter int unsigned CMD_WIDTH = 19
);
  logic                 direct_valid;
  logic                 direct_ready;
  logic [CMD_WIDTH-1:0] direct_cmd;
  logic                 acc_valid;
  logic                 acc_ready;
  logic [CMD_WIDTH-1:0] acc_cmd;
  logic                 ref_valid;
  logic                 ref_ready;
  logic [CMD_WIDTH-1:0] ref_cmd;
  logic                 zqc_valid;
  logic                 zqc_ready;
  logic [CMD_WIDTH-1:0] zqc_cmd;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [CMD_WIDTH-1:0] cmd;
  logic [1:0]           cmd_src;

  modport master (
    output direct_valid, direct_cmd, acc_valid, acc_cmd,
    output ref_valid, ref_cmd, zqc_valid, zqc_cmd, cmd_ready,
    input  direct_ready, acc_ready, ref_ready, zqc_ready,
    input  cmd_valid, cmd, cmd_src
  );

  modport slave (
    input  direct_valid, direct_cmd, acc_valid, acc_cmd,
    input  ref_valid, ref_cmd, zqc_valid, zqc_cmd, cmd_ready,
    output direct_ready, acc_ready, ref_ready, zqc_ready,
    output cmd_valid, cmd, cmd_src
  );
endinterface

// File: rtl/rpc_cmd_out_slot.sv
// One-entry registered output slot. A new entry may be loaded in the same
// cycle the old one is consumed, giving one transfer per cycle.
module rpc_cmd_out_slot
  import rpc_config_path_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 21
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  slot_free_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o
);

  slot_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // in_valid_i is only raised while slot_free_o, so a load never overwrites a held entry.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (in_valid_i) begin
      data_d = in_data_i;
    end
    case (state_q)
      SLOT_EMPTY: if (in_valid_i) state_d = SLOT_FULL;
      SLOT_FULL:  if (out_ready_i && !in_valid_i) state_d = SLOT_EMPTY;
    endcase
  end

  assign out_valid_o = (state_q == SLOT_FULL);
  assign slot_free_o = !out_valid_o || out_ready_i;
  assign out_data_o  = data_q;

endmodule

// File: rtl/rpc_cmd_scheduler.sv
// Arbitrates direct/access/refresh/ZQ commands onto the single CMD_FSM path,
// bounding how long maintenance can be starved by memory accesses.
module rpc_cmd_scheduler
  import rpc_config_path_pkg::*;
#(
  parameter int unsigned CMD_WIDTH = 19,
  parameter int unsigned MAX_DEFER = 8
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           rpc_init_completed_i,
  rpc_cmd_scheduler_if.slave bus,
  output logic           defer_sat_o
);

  localparam int unsigned DEFER_W = (MAX_DEFER == 0) ? 1 : $clog2(MAX_DEFER + 1);
  localparam logic [DEFER_W-1:0] DEFER_MAX = DEFER_W'(MAX_DEFER);
  // Two-bit source tags, highest priority in the least significant field.
  localparam logic [7:0] NORMAL_PRIO = {SRC_ZQC, SRC_REF, SRC_ACC, SRC_DIRECT};
  localparam logic [7:0] FORCED_PRIO = {SRC_ACC, SRC_DIRECT, SRC_ZQC, SRC_REF};

  logic [DEFER_W-1:0]   defer_q, defer_d;
  logic [3:0]           req;
  logic                 forced;
  logic [7:0]           prio;
  logic [1:0]           idx;
  logic                 sel_valid;
  rpc_cmd_src_e         sel_src;
  logic [CMD_WIDTH-1:0] sel_cmd;
  logic                 grant;
  logic                 slot_free;
  logic                 maint_pending;
  logic [CMD_WIDTH+1:0] slot_data;

  assign forced        = (defer_q == DEFER_MAX);
  assign defer_sat_o   = forced;
  assign maint_pending = bus.ref_valid || bus.zqc_valid;
  assign req = {bus.zqc_valid & rpc_init_completed_i, bus.ref_valid & rpc_init_completed_i,
                bus.acc_valid & rpc_init_completed_i, bus.direct_valid};

  // Walk the table from lowest to highest priority so the last hit wins.
  always_comb begin
    sel_valid = 1'b0;
    sel_src   = SRC_DIRECT;
    idx       = 2'd0;
    prio      = forced ? FORCED_PRIO : NORMAL_PRIO;
    for (int i = 3; i >= 0; i--) begin
      idx = prio[2*i +: 2];
      if (req[idx]) begin
        sel_valid = 1'b1;
        sel_src   = rpc_cmd_src_e'(idx);
      end
    end
  end

  always_comb begin
    sel_cmd = bus.direct_cmd;
    case (sel_src)
      SRC_DIRECT: sel_cmd = bus.direct_cmd;
      SRC_ACC:    sel_cmd = bus.acc_cmd;
      SRC_REF:    sel_cmd = bus.ref_cmd;
      SRC_ZQC:    sel_cmd = bus.zqc_cmd;
    endcase
  end

  assign grant            = sel_valid && slot_free && rst_ni;
  assign bus.direct_ready = grant && (sel_src == SRC_DIRECT);
  assign bus.acc_ready    = grant && (sel_src == SRC_ACC);
  assign bus.ref_ready    = grant && (sel_src == SRC_REF);
  assign bus.zqc_ready    = grant && (sel_src == SRC_ZQC);

  // A forced refresh leaves the counter saturated if ZQ is still waiting,
  // so ZQ follows immediately instead of losing to accesses again.
  always_comb begin
    defer_d = defer_q;
    if (grant && (sel_src == SRC_REF || sel_src == SRC_ZQC)) begin
      defer_d = (forced && sel_src == SRC_REF && bus.zqc_valid) ? DEFER_MAX : '0;
    end else if (!maint_pending) begin
      defer_d = '0;
    end else if (grant && sel_src == SRC_ACC && !forced) begin
      defer_d = defer_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      defer_q <= '0;
    end else begin
      defer_q <= defer_d;
    end
  end

  rpc_cmd_out_slot #(
    .DATA_WIDTH(CMD_WIDTH + 2)
  ) u_out_slot (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .in_valid_i (grant),
    .in_data_i  ({sel_src, sel_cmd}),
    .slot_free_o(slot_free),
    .out_valid_o(bus.cmd_valid),
    .out_ready_i(bus.cmd_ready),
    .out_data_o (slot_data)
  );

  assign bus.cmd_src = slot_data[CMD_WIDTH +: 2];
  assign bus.cmd     = slot_data[CMD_WIDTH-1:0];

endmodule
